// File: rtl/wifi2uart_tx_if.sv
// wifi2uart_tx_if: byte write handshake from the WiFi payload side into
// the return-path UART transmitter.
interface wifi2uart_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/wifi2uart_tx.sv
// wifi2uart_tx: return-path UART transmitter for the uart2wifi bridge.
// Bytes from the WiFi side are queued in a FIFO and sent as 8N1 frames.
// Optional feature macro: WIFI2UART_TX_PARITY_EN adds an even parity bit
// (8E1 frames).
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (tx=0)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (only with WIFI2UART_TX_PARITY_EN)
// STOP   | STOP_BITS bit times of tx=1, then next frame or IDLE
module wifi2uart_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 16,
  parameter int STOP_BITS   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  wifi2uart_tx_if.slave                   wr,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  input  logic                            overflow_clr
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef WIFI2UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_nx;
  logic [BW-1:0] baud_cnt, baud_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic          stop_idx, stop_nx;
  logic [7:0]    frame_byte, frame_byte_nx;
  logic          tx_nx;
  logic          pop;
  logic          push;
  logic          ready_en;
  logic          fifo_empty;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];

  // ready_en keeps in_ready low until the first edge after reset release
  assign fifo_empty  = (fifo_count == '0);
  assign wr.in_ready = ready_en && (fifo_count != FULL);
  assign push        = wr.in_valid && wr.in_ready;
  assign busy        = (state != IDLE) || !fifo_empty;

  // FIFO storage; entries need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.in_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ready_en   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // a write attempt while full beats a simultaneous clear
      if (wr.in_valid && !wr.in_ready) overflow <= 1'b1;
      else if (overflow_clr)           overflow <= 1'b0;
    end
  end

  // FSM and serialiser registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      frame_byte <= '0;
      tx         <= 1'b1;
    end else begin
      state      <= state_nx;
      baud_cnt   <= baud_nx;
      bit_idx    <= bit_nx;
      stop_idx   <= stop_nx;
      frame_byte <= frame_byte_nx;
      tx         <= tx_nx;
    end
  end

  // next-state, bit timing and registered tx value
  always_comb begin
    state_nx      = state;
    baud_nx       = baud_cnt;
    bit_nx        = bit_idx;
    stop_nx       = stop_idx;
    frame_byte_nx = frame_byte;
    tx_nx         = tx;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (!fifo_empty) begin
          pop           = 1'b1;
          frame_byte_nx = mem[rd_ptr];
          baud_nx       = BAUD_LOAD;
          state_nx      = START;
          tx_nx         = 1'b0;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          baud_nx  = BAUD_LOAD;
          bit_nx   = '0;
          state_nx = DATA;
          tx_nx    = frame_byte[0];
        end else begin
          baud_nx = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_nx = BAUD_LOAD;
          if (bit_idx == 3'd7) begin
`ifdef WIFI2UART_TX_PARITY_EN
            state_nx = PARITY;
            tx_nx    = ^frame_byte;
`else
            state_nx = STOP;
            stop_nx  = 1'b0;
            tx_nx    = 1'b1;
`endif
          end else begin
            bit_nx = bit_idx + 1'b1;
            tx_nx  = frame_byte[bit_nx];
          end
        end else begin
          baud_nx = baud_cnt - 1'b1;
        end
      end
`ifdef WIFI2UART_TX_PARITY_EN
      PARITY: begin
        if (baud_cnt == '0) begin
          baud_nx  = BAUD_LOAD;
          stop_nx  = 1'b0;
          state_nx = STOP;
          tx_nx    = 1'b1;
        end else begin
          baud_nx = baud_cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_cnt == '0) begin
          if (stop_idx == LAST_STOP) begin
            // chain straight into the next start bit when data is waiting
            if (!fifo_empty) begin
              pop           = 1'b1;
              frame_byte_nx = mem[rd_ptr];
              baud_nx       = BAUD_LOAD;
              state_nx      = START;
              tx_nx         = 1'b0;
            end else begin
              state_nx = IDLE;
              tx_nx    = 1'b1;
            end
          end else begin
            stop_nx = stop_idx + 1'b1;
            baud_nx = BAUD_LOAD;
          end
        end else begin
          baud_nx = baud_cnt - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

endmodule
